// File: rtl/nim_pkg.sv
// Shared types and default widths for the NIM pulse output block.
// The GAP state only exists when NIM_OUT_BURST_EN is defined.
package nim_pkg;

    localparam int NIM_CNT_W  = 32;
    localparam int NIM_TIME_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        HIGH,
`ifdef NIM_OUT_BURST_EN
        GAP,
`endif
        HOLDOFF
    } nim_state_t;

endpackage

// File: rtl/nim_downcounter.sv
// Loadable down-counter with zero flag; one instance times every FSM phase.
module nim_downcounter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/nim_output.sv
// Triggered NIM pulse generator with delay, width, holdoff and polarity control.
// Define NIM_OUT_BURST_EN to honour burst_n/period (multi-pulse bursts).
module nim_output
    import nim_pkg::*;
#(
    parameter int CNT_W  = NIM_CNT_W,
    parameter int TIME_W = NIM_TIME_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              trig_in,
    input  logic [7:0]        delay,
    input  logic [TIME_W-1:0] width,
    input  logic [TIME_W-1:0] holdoff,
    input  logic [7:0]        burst_n,
    input  logic [TIME_W-1:0] period,
    input  logic              invert,
    input  logic              reset_cnt,
    output logic              nim_out,
    output logic              busy,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  dropped
);

    nim_state_t        state;
    logic              raw;
    logic              accept;
    logic              ctr_load;
    logic [TIME_W-1:0] ctr_val;
    logic              ctr_zero;

    logic [7:0]        delay_z;
    logic [TIME_W-1:0] width_z;
    logic [TIME_W-1:0] holdoff_z;
    logic              invert_z;
    logic [TIME_W-1:0] width_s;
    logic [TIME_W-1:0] holdoff_s;

`ifdef NIM_OUT_BURST_EN
    logic [7:0]        burst_n_z;
    logic [TIME_W-1:0] period_z;
    logic [TIME_W-1:0] period_s;
    logic [7:0]        remaining;
`else
    logic              unused_cfg;
    assign unused_cfg = ^{burst_n, period};
`endif

    // Phases last max(v,1) cycles, so the counter is loaded with v-1.
    function automatic logic [TIME_W-1:0] len_m1(input logic [TIME_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            delay_z   <= '0;
            width_z   <= '0;
            holdoff_z <= '0;
            invert_z  <= 1'b0;
`ifdef NIM_OUT_BURST_EN
            burst_n_z <= '0;
            period_z  <= '0;
`endif
        end else begin
            delay_z   <= delay;
            width_z   <= width;
            holdoff_z <= holdoff;
            invert_z  <= invert;
`ifdef NIM_OUT_BURST_EN
            burst_n_z <= burst_n;
            period_z  <= period;
`endif
        end
    end

    assign accept = (state == IDLE) && trig_in && enable;

    always_comb begin
        ctr_load = 1'b0;
        ctr_val  = '0;
        case (state)
            IDLE: if (accept) begin
                ctr_load = 1'b1;
                ctr_val  = (delay_z != '0) ? TIME_W'(delay_z) - 1'b1 : len_m1(width_z);
            end
            DELAY: if (ctr_zero) begin
                ctr_load = 1'b1;
                ctr_val  = len_m1(width_s);
            end
            HIGH: if (ctr_zero) begin
`ifdef NIM_OUT_BURST_EN
                if (remaining != '0) begin
                    ctr_load = 1'b1;
                    ctr_val  = len_m1(period_s);
                end else
`endif
                if (holdoff_s != '0) begin
                    ctr_load = 1'b1;
                    ctr_val  = holdoff_s - 1'b1;
                end
            end
`ifdef NIM_OUT_BURST_EN
            GAP: if (ctr_zero) begin
                ctr_load = 1'b1;
                ctr_val  = len_m1(width_s);
            end
`endif
            default: ;
        endcase
    end

    nim_downcounter #(.W(TIME_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (ctr_load),
        .load_val (ctr_val),
        .zero     (ctr_zero)
    );

    // raw and busy trail the state by one edge, which places the first
    // pulse edge at acceptance + 1 + delay.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            raw       <= 1'b0;
            busy      <= 1'b0;
            width_s   <= '0;
            holdoff_s <= '0;
`ifdef NIM_OUT_BURST_EN
            period_s  <= '0;
            remaining <= '0;
`endif
        end else begin
            raw  <= (state == HIGH);
            busy <= (state != IDLE);
            case (state)
                IDLE: if (accept) begin
                    width_s   <= width_z;
                    holdoff_s <= holdoff_z;
`ifdef NIM_OUT_BURST_EN
                    period_s  <= period_z;
                    remaining <= (burst_n_z == '0) ? '0 : burst_n_z - 8'd1;
`endif
                    state     <= (delay_z != '0) ? DELAY : HIGH;
                end
                DELAY: if (ctr_zero) state <= HIGH;
                HIGH: if (ctr_zero) begin
`ifdef NIM_OUT_BURST_EN
                    if (remaining != '0) begin
                        remaining <= remaining - 8'd1;
                        state     <= GAP;
                    end else
`endif
                    if (holdoff_s != '0) state <= HOLDOFF;
                    else state <= IDLE;
                end
`ifdef NIM_OUT_BURST_EN
                GAP: if (ctr_zero) state <= HIGH;
`endif
                HOLDOFF: if (ctr_zero) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A clear in the same cycle as an increment leaves the counter at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            dropped <= '0;
        end else if (reset_cnt) begin
            count   <= '0;
            dropped <= '0;
        end else begin
            if ((state == HIGH) && !raw) count <= count + 1'b1;
            if (trig_in && (state != IDLE)) dropped <= dropped + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) nim_out <= 1'b0;
        else nim_out <= raw ^ invert_z;
    end

endmodule

// File: tb/tb_nim_output.sv
// Randomized bench for nim_output against a pulse-schedule reference model.
module tb_nim_output;

    localparam int CNT_W  = 8;
    localparam int TIME_W = 16;
    localparam int MAXE   = 8192;
`ifdef NIM_OUT_BURST_EN
    localparam int BURST_PULSES = 3;
`else
    localparam int BURST_PULSES = 1;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              trig_in = 1'b0;
    logic [7:0]        delay = '0;
    logic [TIME_W-1:0] width = '0;
    logic [TIME_W-1:0] holdoff = '0;
    logic [7:0]        burst_n = '0;
    logic [TIME_W-1:0] period = '0;
    logic              invert = 1'b0;
    logic              reset_cnt = 1'b0;
    logic              nim_out;
    logic              busy;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  dropped;

    always #5 clk = ~clk;

    nim_output #(.CNT_W(CNT_W), .TIME_W(TIME_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .trig_in   (trig_in),
        .delay     (delay),
        .width     (width),
        .holdoff   (holdoff),
        .burst_n   (burst_n),
        .period    (period),
        .invert    (invert),
        .reset_cnt (reset_cnt),
        .nim_out   (nim_out),
        .busy      (busy),
        .count     (count),
        .dropped   (dropped)
    );

    int tests = 0;
    int fails = 0;
    int edge_n = 0;

    // Model: per-edge plan of the raw pulse level and its rising edges.
    bit raw_plan [MAXE];
    bit rise_plan [MAXE];
    int busy_end = -1;
    logic [CNT_W-1:0] m_count = '0;
    logic [CNT_W-1:0] m_dropped = '0;
    int d_z, w_z, h_z, b_z, p_z;
    bit inv_z, m_nim, m_busy;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = edge_n; i < MAXE; i++) begin
            raw_plan[i]  = 1'b0;
            rise_plan[i] = 1'b0;
        end
        busy_end = -1;
        m_count = '0;
        m_dropped = '0;
        d_z = 0; w_z = 0; h_z = 0; b_z = 0; p_z = 0;
        inv_z = 1'b0;
        m_nim = 1'b0;
        m_busy = 1'b0;
    endtask

    task automatic schedule(input int e);
        int w, b, p, start, last;
        w = (w_z == 0) ? 1 : w_z;
        p = (p_z == 0) ? 1 : p_z;
`ifdef NIM_OUT_BURST_EN
        b = (b_z == 0) ? 1 : b_z;
`else
        b = 1;
`endif
        start = e + 1 + d_z;
        last = start;
        for (int i = 0; i < b; i++) begin
            if (start < MAXE) rise_plan[start] = 1'b1;
            for (int j = 0; j < w; j++)
                if (start + j < MAXE) raw_plan[start + j] = 1'b1;
            last = start + w - 1;
            start = start + w + p;
        end
        busy_end = last + h_z;
    endtask

    task automatic modelEdge();
        int e;
        bit idle;
        e = edge_n;
        if (reset == 1'b0) begin
            modelReset();
            return;
        end
        m_nim = raw_plan[e-1] ^ inv_z;
        idle = (e > busy_end);
        m_busy = !idle;
        if (rise_plan[e]) m_count++;
        if (!idle && trig_in) m_dropped++;
        if (reset_cnt) begin
            m_count = '0;
            m_dropped = '0;
        end
        if (idle && trig_in && enable) schedule(e);
        d_z = int'(delay);
        w_z = int'(width);
        h_z = int'(holdoff);
        b_z = int'(burst_n);
        p_z = int'(period);
        inv_z = invert;
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        edge_n++;
        modelEdge();
        #1;
        checkOutput("nim_out", nim_out, m_nim);
        checkOutput("busy", busy, m_busy);
        checkOutput("count", count, m_count);
        checkOutput("dropped", dropped, m_dropped);
    endtask

    task automatic setConfig(input int d, input int w, input int h, input int b, input int p);
        delay = d[7:0];
        width = w[TIME_W-1:0];
        holdoff = h[TIME_W-1:0];
        burst_n = b[7:0];
        period = p[TIME_W-1:0];
    endtask

    // Called just after an edge; drops reset mid-cycle and holds it across two edges.
    task automatic asyncReset();
        #2;
        reset = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_nim", nim_out, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_dropped", dropped, 0);
        repeat (2) applyStimulus();
        #2;
        reset = 1'b1;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, edge %0d", edge_n);
        $fatal(1);
    end

    initial begin
        int pulses;
        bit wrap_checked;

        #1 reset = 1'b0;
        modelReset();
        repeat (2) applyStimulus();
        #2 reset = 1'b1;
        checkOutput("init_nim", nim_out, 0);
        checkOutput("init_busy", busy, 0);
        checkOutput("init_count", count, 0);
        checkOutput("init_dropped", dropped, 0);
        enable = 1'b1;

        // Single delayed pulse
        setConfig(3, 5, 0, 1, 0);
        repeat (2) applyStimulus();
        trig_in = 1'b1;
        applyStimulus();
        trig_in = 1'b0;
        repeat (14) applyStimulus();
        checkOutput("single_count", count, 1);

        // Burst of pulses separated by gaps
        setConfig(0, 2, 0, 3, 4);
        repeat (2) applyStimulus();
        trig_in = 1'b1;
        applyStimulus();
        trig_in = 1'b0;
        repeat (30) applyStimulus();
        checkOutput("burst_count", count, 1 + BURST_PULSES);

        // Held trigger across a holdoff window
        setConfig(0, 10, 20, 1, 0);
        repeat (2) applyStimulus();
        trig_in = 1'b1;
        repeat (40) applyStimulus();
        trig_in = 1'b0;
        repeat (25) applyStimulus();
        checkOutput("holdoff_count", count, 3 + BURST_PULSES);

        // Trigger ignored while disabled
        enable = 1'b0;
        trig_in = 1'b1;
        repeat (4) applyStimulus();
        trig_in = 1'b0;
        enable = 1'b1;
        checkOutput("disabled_dropped", busy, 0);

        // Inverted polarity in idle and during a pulse
        invert = 1'b1;
        repeat (3) applyStimulus();
        checkOutput("inv_idle", nim_out, 1);
        setConfig(0, 3, 0, 1, 0);
        repeat (2) applyStimulus();
        trig_in = 1'b1;
        applyStimulus();
        trig_in = 1'b0;
        repeat (8) applyStimulus();
        invert = 1'b0;
        repeat (3) applyStimulus();

        // Reset in the middle of a burst pulse
        setConfig(1, 4, 0, 3, 2);
        repeat (2) applyStimulus();
        trig_in = 1'b1;
        applyStimulus();
        trig_in = 1'b0;
        repeat (4) applyStimulus();
        checkOutput("pre_rst_nim", nim_out, 1);
        asyncReset();
        repeat (30) applyStimulus();
        checkOutput("post_rst_count", count, 0);

        // Counter wrap, then clear colliding with an increment
        setConfig(0, 1, 0, 1, 0);
        repeat (2) applyStimulus();
        trig_in = 1'b1;
        pulses = 0;
        wrap_checked = 1'b0;
        for (int i = 0; i < 520; i++) begin
            applyStimulus();
            if (rise_plan[edge_n]) pulses++;
            if (pulses == 256 && !wrap_checked) begin
                checkOutput("count_wrap", count, 0);
                wrap_checked = 1'b1;
            end
        end
        for (int i = 0; i < 12; i++) begin
            reset_cnt = rise_plan[edge_n + 1] && (i > 4);
            applyStimulus();
            if (reset_cnt) checkOutput("clr_wins", count, 0);
        end
        reset_cnt = 1'b0;
        trig_in = 1'b0;
        repeat (3) applyStimulus();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            trig_in = ($urandom_range(0, 3) == 0);
            enable = ($urandom_range(0, 7) != 0);
            reset_cnt = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 19) == 0)
                setConfig($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 5),
                          $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) invert = ~invert;
            applyStimulus();
            if ($urandom_range(0, 399) == 0) asyncReset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
